// File: rtl/pipeline_trace_buffer_pkg.sv
// Shared encodings for the pipeline retire-trace buffer: capture modes, control states,
// and the mode-to-state mapping used on entry and after a clear.
package pipeline_trace_buffer_pkg;

    typedef enum logic [1:0] {
        MODE_OFF       = 2'b00,
        MODE_CONT      = 2'b01,
        MODE_STOP_FULL = 2'b10,
        MODE_TRIGGER   = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_ARMED  = 3'd2,
        ST_POST   = 3'd3,
        ST_FROZEN = 3'd4
    } state_e;

    localparam int RD_W = 5;

    function automatic state_e state_for_mode(input logic [1:0] mode);
        case (mode)
            MODE_OFF:       return ST_IDLE;
            MODE_CONT:      return ST_RUN;
            MODE_STOP_FULL: return ST_RUN;
            MODE_TRIGGER:   return ST_ARMED;
            default:        return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/pipeline_trace_buffer_ring_ram.sv
// Trace entry storage: one synchronous write port, one asynchronous read port.
// Contents are not reset; the control logic masks entries that are not valid.
module pipeline_trace_buffer_ring_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 69
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage write on the capture edge
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pipeline_trace_buffer.sv
// Retire-trace ring buffer with capture modes and saturating event counters.
// Entries are packed {pc, rd, data} and drain oldest-first through a valid/ready port.
module pipeline_trace_buffer
    import pipeline_trace_buffer_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8,
    parameter int CNT_W     = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 mode,
    input  logic                       clear,
    input  logic [XLEN-1:0]            trig_pc,
    input  logic                       wb_valid,
    input  logic [XLEN-1:0]            wb_pc,
    input  logic [RD_W-1:0]            wb_rd,
    input  logic [XLEN-1:0]            wb_data,
    input  logic                       stall,
    input  logic                       branch_taken,
    input  logic [1:0]                 fwd_a,
    input  logic [1:0]                 fwd_b,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [XLEN-1:0]            rd_pc,
    output logic [RD_W-1:0]            rd_rd,
    output logic [XLEN-1:0]            rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       frozen,
    output logic                       overflow,
    output logic [CNT_W-1:0]           cnt_retire,
    output logic [CNT_W-1:0]           cnt_stall,
    output logic [CNT_W-1:0]           cnt_branch,
    output logic [CNT_W-1:0]           cnt_fwd
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 2 * XLEN + RD_W;
    localparam int PW = $clog2(POST_TRIG + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    state_e          state_r;
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic [PW-1:0]   post_cnt_r;
    logic            overflow_r;
    logic [CNT_W-1:0] cnt_retire_r, cnt_stall_r, cnt_branch_r, cnt_fwd_r;

    logic            active_s, rd_valid_s, full_s, do_write_s, do_pop_s;
    logic            trig_hit_s, reaches_full_s;
    logic [EW-1:0]   rd_entry_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic ev);
        if (ev && (v != {CNT_W{1'b1}})) begin
            return v + CNT_W'(1);
        end else begin
            return v;
        end
    endfunction

    assign active_s    = (state_r == ST_RUN) || (state_r == ST_ARMED) || (state_r == ST_POST);
    assign rd_valid_s  = (count_r != {CW{1'b0}});
    assign full_s      = (count_r == DEPTH_C);
    assign do_write_s  = active_s && wb_valid;
    assign do_pop_s    = rd_valid_s && rd_ready;
    assign trig_hit_s  = do_write_s && (wb_pc == trig_pc);
    // Count lands on DEPTH after this edge: a paired pop keeps it level only when already full
    assign reaches_full_s = do_write_s && (full_s || (!do_pop_s && (count_r == DEPTH_C - CW'(1))));

    pipeline_trace_buffer_ring_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_ram (
        .clk   (clk),
        .we    (do_write_s && !clear),
        .waddr (wr_ptr_r),
        .wdata ({wb_pc, wb_rd, wb_data}),
        .raddr (rd_ptr_r),
        .rdata (rd_entry_s)
    );

    // Capture control state and post-trigger countdown
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            post_cnt_r <= {PW{1'b0}};
        end else if (clear) begin
            state_r    <= state_for_mode(mode);
            post_cnt_r <= {PW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: state_r <= state_for_mode(mode);
                ST_RUN: begin
                    if (mode == MODE_OFF) begin
                        state_r <= ST_IDLE;
                    end else if ((mode == MODE_STOP_FULL) && reaches_full_s) begin
                        state_r <= ST_FROZEN;
                    end else begin
                        state_r <= state_for_mode(mode);
                    end
                end
                ST_ARMED: begin
                    if (mode == MODE_OFF) begin
                        state_r <= ST_IDLE;
                    end else if (trig_hit_s) begin
                        // The trigger entry itself is the first of the post-trigger window
                        if (POST_TRIG == 1) begin
                            state_r <= ST_FROZEN;
                        end else begin
                            state_r    <= ST_POST;
                            post_cnt_r <= PW'(POST_TRIG - 1);
                        end
                    end else begin
                        state_r <= state_for_mode(mode);
                    end
                end
                ST_POST: begin
                    if (do_write_s) begin
                        post_cnt_r <= post_cnt_r - PW'(1);
                        if (post_cnt_r == PW'(1)) begin
                            state_r <= ST_FROZEN;
                        end
                    end
                end
                ST_FROZEN: state_r <= ST_FROZEN;
                default:   state_r <= ST_IDLE;
            endcase
        end
    end

    // Ring pointers, occupancy and sticky overflow
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            overflow_r <= 1'b0;
        end else if (clear) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (do_write_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            // A write into a full ring without a pop pushes the oldest entry out
            if (do_pop_s || (do_write_s && full_s)) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            if (do_write_s && full_s && !do_pop_s) begin
                overflow_r <= 1'b1;
            end
            if (do_write_s && !do_pop_s && !full_s) begin
                count_r <= count_r + CW'(1);
            end else if (!do_write_s && do_pop_s) begin
                count_r <= count_r - CW'(1);
            end
        end
    end

    // Saturating event counters, live only while capturing
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_retire_r <= {CNT_W{1'b0}};
            cnt_stall_r  <= {CNT_W{1'b0}};
            cnt_branch_r <= {CNT_W{1'b0}};
            cnt_fwd_r    <= {CNT_W{1'b0}};
        end else if (clear) begin
            cnt_retire_r <= {CNT_W{1'b0}};
            cnt_stall_r  <= {CNT_W{1'b0}};
            cnt_branch_r <= {CNT_W{1'b0}};
            cnt_fwd_r    <= {CNT_W{1'b0}};
        end else if (active_s) begin
            cnt_retire_r <= sat_inc(cnt_retire_r, wb_valid);
            cnt_stall_r  <= sat_inc(cnt_stall_r, stall);
            cnt_branch_r <= sat_inc(cnt_branch_r, branch_taken);
            cnt_fwd_r    <= sat_inc(cnt_fwd_r, (fwd_a != 2'b00) || (fwd_b != 2'b00));
        end
    end

    // Read port shows nothing unless an entry is held, so stale RAM never leaks out
    always_comb begin
        if (rd_valid_s) begin
            rd_pc   = rd_entry_s[EW-1 -: XLEN];
            rd_rd   = rd_entry_s[XLEN+RD_W-1 -: RD_W];
            rd_data = rd_entry_s[XLEN-1:0];
        end else begin
            rd_pc   = {XLEN{1'b0}};
            rd_rd   = {RD_W{1'b0}};
            rd_data = {XLEN{1'b0}};
        end
    end

    assign rd_valid   = rd_valid_s;
    assign count      = count_r;
    assign full       = full_s;
    assign frozen     = (state_r == ST_FROZEN);
    assign overflow   = overflow_r;
    assign cnt_retire = cnt_retire_r;
    assign cnt_stall  = cnt_stall_r;
    assign cnt_branch = cnt_branch_r;
    assign cnt_fwd    = cnt_fwd_r;

endmodule
